// File: rtl/traffic_phase_ctrl.sv
// Two-road (main/side) traffic phase controller with all-red clearance,
// side-green gap-out/max-out, night flash mode and decoded lamp outputs.
module traffic_phase_ctrl #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned MAIN_MIN_GREEN = 25,
  parameter int unsigned SIDE_MIN_GREEN = 10,
  parameter int unsigned SIDE_MAX_GREEN = 30,
  parameter int unsigned YELLOW_T       = 3,
  parameter int unsigned ALLRED_T       = 1
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             side_sensor,
  input  logic             flash_mode,
  output logic [2:0]       state,
  output logic [2:0]       main_lamp,
  output logic [2:0]       side_lamp,
  output logic [CNT_W-1:0] remain,
  output logic             phase_change
);

  typedef enum logic [2:0] {
    S_MG    = 3'd0,
    S_MY    = 3'd1,
    S_AR1   = 3'd2,
    S_CG    = 3'd3,
    S_CY    = 3'd4,
    S_AR2   = 3'd5,
    S_FLASH = 3'd6,
    S_BAD   = 3'd7
  } phase_e;

  localparam logic [CNT_W-1:0] MAIN_LOAD   = CNT_W'(MAIN_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] SMAX_LOAD   = CNT_W'(SIDE_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LOAD    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LOAD     = CNT_W'(ALLRED_T - 1);
  // Once remain drops to this value the side road has had its minimum green.
  localparam logic [CNT_W-1:0] GAP_LIMIT   = CNT_W'(SIDE_MAX_GREEN - SIDE_MIN_GREEN);

  phase_e           r_state;
  phase_e           w_nextState;
  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] w_nextRemain;
  logic             r_blink;
  logic             w_nextBlink;
  logic             r_phaseChange;
  logic             w_expired;

  always_comb begin
    w_expired    = (r_remain == '0);
    w_nextState  = r_state;
    w_nextRemain = w_expired ? '0 : (r_remain - CNT_W'(1));
    w_nextBlink  = 1'b0;
    // Flash request overrides every timer-driven transition.
    if (flash_mode && (r_state != S_FLASH)) begin
      w_nextState  = S_FLASH;
      w_nextRemain = '0;
    end else begin
      case (r_state)
        S_MG: begin
          if (w_expired && side_sensor) begin
            w_nextState  = S_MY;
            w_nextRemain = YEL_LOAD;
          end
        end
        S_MY: begin
          if (w_expired) begin
            w_nextState  = S_AR1;
            w_nextRemain = AR_LOAD;
          end
        end
        S_AR1: begin
          if (w_expired) begin
            w_nextState  = S_CG;
            w_nextRemain = SMAX_LOAD;
          end
        end
        S_CG: begin
          if (w_expired || ((r_remain <= GAP_LIMIT) && !side_sensor)) begin
            w_nextState  = S_CY;
            w_nextRemain = YEL_LOAD;
          end
        end
        S_CY: begin
          if (w_expired) begin
            w_nextState  = S_AR2;
            w_nextRemain = AR_LOAD;
          end
        end
        S_AR2: begin
          if (w_expired) begin
            w_nextState  = S_MG;
            w_nextRemain = MAIN_LOAD;
          end
        end
        S_FLASH: begin
          if (flash_mode) begin
            w_nextBlink  = ~r_blink;
            w_nextRemain = '0;
          end else begin
            w_nextState  = S_AR2;
            w_nextRemain = AR_LOAD;
          end
        end
        default: begin
          w_nextState  = S_MG;
          w_nextRemain = MAIN_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge div_clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_MG;
      r_remain      <= MAIN_LOAD;
      r_blink       <= 1'b0;
      r_phaseChange <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_remain      <= w_nextRemain;
      r_blink       <= w_nextBlink;
      r_phaseChange <= (w_nextState != r_state);
    end
  end

  // Lamp bit order is {R,Y,G}; an illegal state shows all lamps dark.
  always_comb begin
    main_lamp = 3'b000;
    side_lamp = 3'b000;
    case (r_state)
      S_MG:    begin main_lamp = 3'b001; side_lamp = 3'b100; end
      S_MY:    begin main_lamp = 3'b010; side_lamp = 3'b100; end
      S_AR1:   begin main_lamp = 3'b100; side_lamp = 3'b100; end
      S_CG:    begin main_lamp = 3'b100; side_lamp = 3'b001; end
      S_CY:    begin main_lamp = 3'b100; side_lamp = 3'b010; end
      S_AR2:   begin main_lamp = 3'b100; side_lamp = 3'b100; end
      S_FLASH: begin main_lamp = {1'b0, r_blink, 1'b0}; side_lamp = {r_blink, 2'b00}; end
      default: begin main_lamp = 3'b000; side_lamp = 3'b000; end
    endcase
  end

  assign state        = r_state;
  assign remain       = r_remain;
  assign phase_change = r_phaseChange;

endmodule
